// File: rtl/fil2dma_wr_arb.sv
// Round-robin write arbiter in front of the fil2dma sync FIFO.
// One requester owns the FIFO write port for a whole burst (ended by req_last).
// A local credit counter mirrors free FIFO entries so the FIFO is never overrun.
module fil2dma_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CRED_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      fil_clk,
    input  logic                      fil_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    input  logic                      fifo_pop,
    output logic [ID_W-1:0]           gnt_id,
    output logic                      busy,
    output logic [CRED_W-1:0]         credits,
    output logic                      err_credit_ovf
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CRED_W-1:0]   credits_q, credits_d;
    logic                err_q, err_d;
    logic                wr_en_q;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic [DATA_W-1:0]   lane_data [NUM_REQ];
    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic                transfer;
    logic                last_beat;

    // Split the flat payload bus into one word per requester
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Find the first valid requester at or after rr_ptr (descending scan so the lowest offset wins)
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[ID_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // State register plus all datapath registers; reset wins over any pending push
    always_ff @(posedge fil_clk) begin
        if (fil_rst) begin
            state_q   <= IDLE;
            gnt_id_q  <= '0;
            rr_ptr_q  <= '0;
            credits_q <= CRED_W'(FIFO_DEPTH);
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            rr_ptr_q  <= rr_ptr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            wr_en_q   <= transfer;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state: arbitrate in IDLE, leave GRANT on the accepted last beat
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = GRANT;
            GRANT:   if (transfer && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready only from registered state so there is no valid->ready path
    always_comb begin
        req_ready = '0;
        busy      = (state_q == GRANT);
        if (state_q == GRANT && credits_q != '0) begin
            req_ready[gnt_id_q] = 1'b1;
        end
        transfer  = |(req_valid & req_ready);
        last_beat = req_last[gnt_id_q];
    end

    // Grant id, round-robin pointer and captured push data
    always_comb begin
        gnt_id_d  = gnt_id_q;
        rr_ptr_d  = rr_ptr_q;
        wr_data_d = wr_data_q;
        if (state_q == IDLE && pick_found) begin
            gnt_id_d = pick_id;
        end
        if (transfer) begin
            wr_data_d = lane_data[gnt_id_q];
            if (last_beat) begin
                rr_ptr_d = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
            end
        end
    end

    // Credits: reserve on transfer, return on pop; a pop with nothing outstanding is flagged
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({transfer, fifo_pop})
            2'b10: credits_d = credits_q - CRED_W'(1);
            2'b01: begin
                if (credits_q == CRED_W'(FIFO_DEPTH)) begin
                    err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CRED_W'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    assign fifo_wr_en     = wr_en_q;
    assign fifo_wr_data   = wr_data_q;
    assign gnt_id         = gnt_id_q;
    assign credits        = credits_q;
    assign err_credit_ovf = err_q;

endmodule
